// File: rtl/pwm_multi.sv
// pwm_multi: N_CH independent PWM channels that share one frame counter.
// Each channel has a shadow duty register, written at any time, and an active
// duty register that the compare uses. The active registers load from their
// shadows only at frame wrap or when en rises, so a new duty never lands in
// the middle of a frame.
module pwm_multi #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CANT_BITS = 8,
  parameter int unsigned PERIOD    = 10000,
  parameter int unsigned SD        = 39
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic                                          upd_valid,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]    upd_ch,
  input  logic signed [CANT_BITS-1:0]                   upd_data,
  output logic                                          upd_ready,
  output logic                                          upd_err,
  output logic                                          frame_tick,
  output logic [N_CH-1:0]                               PWM_out
);

  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned D_W    = $clog2(PERIOD + 1);
  localparam int unsigned SD_W   = (SD > 0) ? $clog2(SD + 1) : 1;
  localparam int unsigned PROD_W = CANT_BITS + SD_W;
  localparam int unsigned CMP_W  = (PROD_W > D_W) ? PROD_W : D_W;

  // Flipping the sign bit of a two's-complement command adds 2^(CANT_BITS-1).
  localparam logic [CANT_BITS-1:0] SIGN_FLIP = CANT_BITS'(1) << (CANT_BITS - 1);

  // Neutral duty loaded at reset: 2^(CANT_BITS-1) * SD, clamped to PERIOD.
  localparam longint unsigned CENTRE_RAW = (64'(1) << (CANT_BITS - 1)) * 64'(SD);
  localparam logic [D_W-1:0]  CENTRE     = (CENTRE_RAW > 64'(PERIOD)) ? D_W'(PERIOD)
                                                                      : D_W'(CENTRE_RAW);

  // Signed command -> high-time count, saturated at PERIOD. The product
  // width CMP_W is large enough that the multiply can never overflow.
  function automatic logic [D_W-1:0] duty_of(input logic [CANT_BITS-1:0] cmd);
    logic [CMP_W-1:0] offs;
    logic [CMP_W-1:0] prod;
    logic [D_W-1:0]   res;
    offs = CMP_W'(cmd ^ SIGN_FLIP);
    prod = offs * CMP_W'(SD);
    if (prod > CMP_W'(PERIOD)) begin
      res = D_W'(PERIOD);
    end else begin
      res = D_W'(prod);
    end
    return res;
  endfunction

  logic [CNT_W-1:0]           cnt_q,    cnt_d;
  logic                       en_q,     en_d;
  logic [N_CH-1:0][D_W-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0][D_W-1:0]   active_q, active_d;
  logic [N_CH-1:0]            pwm_q,    pwm_d;
  logic                       tick_q,   tick_d;
  logic                       err_q,    err_d;
  logic                       ready_q,  ready_d;

  logic                       ch_ok;
  logic                       accept;
  logic                       wrap;
  logic                       en_rise;
  logic [D_W-1:0]             wr_duty;
  logic [D_W-1:0]             cnt_ext;

  // Next-state: frame counter, shadow writes, active reload and PWM compare.
  always_comb begin
    cnt_d    = cnt_q;
    en_d     = en;
    shadow_d = shadow_q;
    active_d = active_q;
    pwm_d    = '0;
    tick_d   = 1'b0;
    err_d    = 1'b0;
    ready_d  = 1'b1;

    ch_ok   = (32'(upd_ch) < N_CH);
    accept  = upd_valid && ch_ok;
    wr_duty = duty_of(upd_data);
    wrap    = en && (cnt_q == CNT_W'(PERIOD - 1));
    en_rise = en && !en_q;
    cnt_ext = D_W'(cnt_q);

    // Counter runs 0..PERIOD-1 while enabled and parks at 0 otherwise.
    if (!en || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Shadow takes accepted writes, including writes while disabled.
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (accept && (upd_ch == CH_W'(i))) begin
        shadow_d[i] = wr_duty;
      end
    end

    // Active reloads from the pre-write shadow, so a write on the wrap edge
    // waits one more frame.
    if (wrap || en_rise) begin
      active_d = shadow_q;
    end

    // On the en-rise edge the counter is at 0 of a new frame, so compare
    // against the value being loaded into active rather than the stale one.
    for (int unsigned i = 0; i < N_CH; i++) begin
      pwm_d[i] = en && (cnt_ext < (en_rise ? shadow_q[i] : active_q[i]));
    end

    tick_d = en && (cnt_q == '0);
    err_d  = upd_valid && !ch_ok;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      en_q     <= 1'b0;
      shadow_q <= {N_CH{CENTRE}};
      active_q <= {N_CH{CENTRE}};
      pwm_q    <= '0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign PWM_out    = pwm_q;
  assign frame_tick = tick_q;
  assign upd_err    = err_q;
  assign upd_ready  = ready_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a default instance (4 channels, PERIOD 10000) driven
// from a vector table, and a 5-channel PERIOD 9000 instance for saturation and
// the out-of-range channel error pulse.
module tb_pwm_multi;

  localparam int P_A    = 10000;
  localparam int P_B    = 9000;
  localparam int W_NONE = 0;
  localparam int W_MID  = 1;
  localparam int W_WRAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              en;

  logic              upd_valid_a;
  logic [1:0]        upd_ch_a;
  logic signed [7:0] upd_data_a;
  logic              upd_ready_a;
  logic              upd_err_a;
  logic              frame_tick_a;
  logic [3:0]        pwm_a;

  logic              upd_valid_b;
  logic [2:0]        upd_ch_b;
  logic signed [7:0] upd_data_b;
  logic              upd_ready_b;
  logic              upd_err_b;
  logic              frame_tick_b;
  logic [4:0]        pwm_b;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_multi dut_a (
    .clk(clk), .rst(rst), .en(en),
    .upd_valid(upd_valid_a), .upd_ch(upd_ch_a), .upd_data(upd_data_a),
    .upd_ready(upd_ready_a), .upd_err(upd_err_a),
    .frame_tick(frame_tick_a), .PWM_out(pwm_a)
  );

  pwm_multi #(.N_CH(5), .CANT_BITS(8), .PERIOD(P_B), .SD(39)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .upd_valid(upd_valid_b), .upd_ch(upd_ch_b), .upd_data(upd_data_b),
    .upd_ready(upd_ready_b), .upd_err(upd_err_b),
    .frame_tick(frame_tick_b), .PWM_out(pwm_b)
  );

  typedef struct {
    int wmode;
    int wch;
    int wdata;
    int exp_hi [4];
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input int wmode, input int wch, input int wdata,
                         input int e0, input int e1, input int e2, input int e3);
    vecs[idx].wmode     = wmode;
    vecs[idx].wch       = wch;
    vecs[idx].wdata     = wdata;
    vecs[idx].exp_hi[0] = e0;
    vecs[idx].exp_hi[1] = e1;
    vecs[idx].exp_hi[2] = e2;
    vecs[idx].exp_hi[3] = e3;
  endtask

  // Measure one frame of dut_a starting at its frame_tick, optionally issuing
  // a write mid-frame or in the last cycle before the wrap edge.
  task automatic measure_a(input int wmode, input int wch, input int wdata,
                           output int hi [4], output int ticks,
                           output int shape_bad, output int next_tick);
    int guard;
    guard     = 0;
    hi        = '{0, 0, 0, 0};
    ticks     = 0;
    shape_bad = 0;
    while (frame_tick_a !== 1'b1 && guard < P_A + 4) begin
      @(negedge clk);
      guard++;
    end
    check("a_frame_start", 32'(frame_tick_a === 1'b1), 1);
    for (int j = 0; j < P_A; j++) begin
      for (int c = 0; c < 4; c++) begin
        if (pwm_a[c] === 1'b1) begin
          if (j != hi[c]) shape_bad++;
          hi[c]++;
        end
      end
      if (frame_tick_a === 1'b1) ticks++;
      upd_valid_a = (wmode == W_MID && j == P_A / 2) || (wmode == W_WRAP && j == P_A - 2);
      upd_ch_a    = 2'(wch);
      upd_data_a  = 8'(wdata);
      @(negedge clk);
    end
    upd_valid_a = 1'b0;
    next_tick   = int'(frame_tick_a);
  endtask

  task automatic check_frame_a(input string tag, input int hi [4], input int exp_hi [4],
                               input int ticks, input int shape_bad, input int next_tick);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s_ch%0d_high", tag, c), 32'(hi[c]), 32'(exp_hi[c]));
    end
    check($sformatf("%s_ticks_in_frame", tag), 32'(ticks), 1);
    check($sformatf("%s_tick_period", tag), 32'(next_tick), 1);
    check($sformatf("%s_shape", tag), 32'(shape_bad), 0);
  endtask

  initial begin
    int hi [4];
    int ticks;
    int shape_bad;
    int next_tick;
    int exp_hi [4];

    rst = 1'b1; en = 1'b0;
    upd_valid_a = 1'b0; upd_ch_a = '0; upd_data_a = '0;
    upd_valid_b = 1'b0; upd_ch_b = '0; upd_data_b = '0;

    // 138*39 = 5382, 255*39 = 9945, 0*39 = 0, neutral 128*39 = 4992.
    set_vec(0, W_MID,  1, -128, 4992, 4992, 4992, 4992);
    set_vec(1, W_MID,  2,  127, 4992,    0, 4992, 4992);
    set_vec(2, W_WRAP, 0,   10, 4992,    0, 9945, 4992);
    set_vec(3, W_NONE, 0,    0, 4992,    0, 9945, 4992);
    set_vec(4, W_NONE, 0,    0, 5382,    0, 9945, 4992);

    fork
      begin : main_seq
        repeat (2) @(negedge clk);
        check("rst_pwm",   32'(pwm_a), 0);
        check("rst_tick",  32'(frame_tick_a), 0);
        check("rst_err",   32'(upd_err_a), 0);
        check("rst_ready", 32'(upd_ready_a), 0);
        check("rst_pwm_b", 32'(pwm_b), 0);

        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("first_edge_pwm",  32'(pwm_a), 32'h0000_000F);
        check("first_edge_tick", 32'(frame_tick_a), 1);
        check("ready_after_rst", 32'(upd_ready_a), 1);

        for (int i = 0; i < 5; i++) begin
          measure_a(vecs[i].wmode, vecs[i].wch, vecs[i].wdata, hi, ticks, shape_bad, next_tick);
          check_frame_a($sformatf("vec%0d", i), hi, vecs[i].exp_hi, ticks, shape_bad, next_tick);
        end

        // Disable: outputs drop one clock later, counter parks, writes still land.
        en = 1'b0;
        @(negedge clk);
        check("en_off_pwm",  32'(pwm_a), 0);
        check("en_off_tick", 32'(frame_tick_a), 0);
        upd_valid_a = 1'b1; upd_ch_a = 2'd1; upd_data_a = -8'sd1;
        @(negedge clk);
        upd_valid_a = 1'b0;
        repeat (5) @(negedge clk);
        check("en_off_pwm_held", 32'(pwm_a), 0);
        check("en_off_ready",    32'(upd_ready_a), 1);

        // Re-enable: shadow copies to active on the rising edge of en.
        en = 1'b1;
        @(negedge clk);
        check("en_on_pwm",  32'(pwm_a), 32'h0000_000F);
        check("en_on_tick", 32'(frame_tick_a), 1);
        measure_a(W_NONE, 0, 0, hi, ticks, shape_bad, next_tick);
        exp_hi = '{5382, 4953, 9945, 4992};
        check_frame_a("en_on", hi, exp_hi, ticks, shape_bad, next_tick);

        // Asynchronous reset in the middle of a high pulse.
        repeat (100) @(negedge clk);
        check("pre_rst_pwm", 32'(pwm_a), 32'h0000_000F);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pwm",   32'(pwm_a), 0);
        check("async_rst_ready", 32'(upd_ready_a), 0);
        @(negedge clk);
        rst = 1'b0;
        measure_a(W_NONE, 0, 0, hi, ticks, shape_bad, next_tick);
        exp_hi = '{4992, 4992, 4992, 4992};
        check_frame_a("post_rst", hi, exp_hi, ticks, shape_bad, next_tick);
      end

      begin : aux_seq
        int gb;
        int hb [5];
        int tb_ticks;
        int shape_b;
        int exp_b [2][5];
        exp_b[0] = '{4992, 4992, 4992, 4992, 4992};
        exp_b[1] = '{4992, 4992, 9000, 4992, 4992};
        gb = 0;
        while (rst && gb < 100) begin
          @(negedge clk);
          gb++;
        end
        for (int f = 0; f < 2; f++) begin
          gb = 0;
          while (frame_tick_b !== 1'b1 && gb < P_B + 4) begin
            @(negedge clk);
            gb++;
          end
          check($sformatf("b_frame%0d_start", f), 32'(frame_tick_b === 1'b1), 1);
          hb       = '{0, 0, 0, 0, 0};
          tb_ticks = 0;
          shape_b  = 0;
          for (int j = 0; j < P_B; j++) begin
            for (int c = 0; c < 5; c++) begin
              if (pwm_b[c] === 1'b1) begin
                if (j != hb[c]) shape_b++;
                hb[c]++;
              end
            end
            if (frame_tick_b === 1'b1) tb_ticks++;
            if (f == 0 && j == 100) check("b_err_before", 32'(upd_err_b), 0);
            if (f == 0 && j == 101) check("b_err_pulse",  32'(upd_err_b), 1);
            if (f == 0 && j == 102) check("b_err_after",  32'(upd_err_b), 0);
            upd_valid_b = (f == 0) && (j == 100 || j == 4000);
            upd_ch_b    = (j == 100) ? 3'd5 : 3'd2;
            upd_data_b  = (j == 100) ? -8'sd128 : 8'sd127;
            @(negedge clk);
          end
          upd_valid_b = 1'b0;
          for (int c = 0; c < 5; c++) begin
            check($sformatf("b_frame%0d_ch%0d_high", f, c), 32'(hb[c]), 32'(exp_b[f][c]));
          end
          check($sformatf("b_frame%0d_ticks", f), 32'(tb_ticks), 1);
          check($sformatf("b_frame%0d_tick_period", f), 32'(frame_tick_b), 1);
          check($sformatf("b_frame%0d_shape", f), 32'(shape_b), 0);
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
